// File: rtl/part_event_sched_pkg.sv
// rtl/part_event_sched_pkg.sv - shared types and defaults for the mission-clock event scheduler
// Purpose: scheduler FSM state encoding, default sizing and the index-width helper.
// Ports: none (package).
package part_sched_pkg;

    localparam int N_EV_DEF     = 4;
    localparam int DW_DEF       = 9;
    localparam int WD_LIMIT_DEF = 10000;
    localparam int IW_DEF       = (N_EV_DEF > 1) ? $clog2(N_EV_DEF) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUT  = 2'd1,
        S_GET  = 2'd2,
        S_ERR  = 2'd3
    } sched_state_t;

    // Slot index width; a single-slot build still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/part_event_sched_if.sv
// rtl/part_event_sched_if.sv - fringe channel bundle between scheduler and put/get transport
// Purpose: export (put) and import (get) request/response signals.
// Ports: master = scheduler (drives requests), slave = fringe transport (drives ack/response).
interface part_event_sched_if
    import part_sched_pkg::*;
#(
    parameter int N_EV = N_EV_DEF,
    parameter int DW   = DW_DEF
);
    localparam int IW = idx_w(N_EV);

    logic          put_req;
    logic [IW-1:0] put_idx;
    logic [DW-1:0] put_data;
    logic          put_ack;
    logic          get_req;
    logic [IW-1:0] get_idx;
    logic          get_valid;
    logic [IW-1:0] get_ridx;
    logic [DW-1:0] get_data;

    modport master (
        output put_req, put_idx, put_data, get_req, get_idx,
        input  put_ack, get_valid, get_ridx, get_data
    );

    modport slave (
        input  put_req, put_idx, put_data, get_req, get_idx,
        output put_ack, get_valid, get_ridx, get_data
    );

endinterface

// File: rtl/part_event_sched_rr_arb.sv
// rtl/part_event_sched_rr_arb.sv - N_EV-way round-robin arbiter for pending event slots
// Purpose: grant the lowest requesting slot strictly after the last granted one.
// Ports: clk_i/rst_i, req_i request vector, adv_i commit strobe, gnt_o one-hot grant, gnt_idx_o index.
module part_rr_arb
    import part_sched_pkg::*;
#(
    parameter int N_EV = N_EV_DEF,
    localparam int IW  = idx_w(N_EV)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_EV-1:0] req_i,
    input  logic            adv_i,
    output logic [N_EV-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o
);

    logic [IW-1:0]   last_q;
    logic [N_EV-1:0] req_hi;

    // Requests above the last grant win; otherwise wrap to the lowest request.
    always_comb begin
        req_hi    = '0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        for (int i = 0; i < N_EV; i++) begin
            req_hi[i] = req_i[i] && (IW'(i) > last_q);
        end
        for (int i = N_EV - 1; i >= 0; i--) begin
            if (req_i[i]) gnt_idx_o = IW'(i);
        end
        for (int i = N_EV - 1; i >= 0; i--) begin
            if (req_hi[i]) gnt_idx_o = IW'(i);
        end
        gnt_o[gnt_idx_o] = |req_i;
    end

    // Reset to the top slot so the first search starts at slot 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= IW'(N_EV - 1);
        end else if (adv_i && (|req_i)) begin
            last_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/part_event_sched.sv
// rtl/part_event_sched.sv - mission-clock event scheduler with put/get fringe transactions
// Purpose: detect mission clock edges per slot, serialise export/import transactions, freeze clocks.
// Ports: clk_i/rst_i; clk_h_i, clk_en_i, put_en_i, get_en_i, sut_data_i slot inputs;
//        fringe (master) put/get channel; rcv_valid_o/rcv_data_o received payloads;
//        freeze_clk_o clock holds; busy_o, ov_err_o, wd_err_o status.
module part_event_sched
    import part_sched_pkg::*;
#(
    parameter int N_EV     = N_EV_DEF,
    parameter int DW       = DW_DEF,
    parameter int WD_LIMIT = WD_LIMIT_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_EV-1:0]      clk_h_i,
    input  logic [N_EV-1:0]      clk_en_i,
    input  logic [N_EV-1:0]      put_en_i,
    input  logic [N_EV-1:0]      get_en_i,
    input  logic [N_EV*DW-1:0]   sut_data_i,
    part_event_sched_if.master   fringe,
    output logic [N_EV-1:0]      rcv_valid_o,
    output logic [N_EV*DW-1:0]   rcv_data_o,
    output logic [N_EV-1:0]      freeze_clk_o,
    output logic                 busy_o,
    output logic                 ov_err_o,
    output logic                 wd_err_o
);

    localparam int IW  = idx_w(N_EV);
    localparam int WDW = $clog2(WD_LIMIT + 1);

    sched_state_t       state_q;
    logic [N_EV-1:0]    clk_h_q, pending_q, pending_d, ev_edge, clr, gnt;
    logic [IW-1:0]      gnt_idx, idx_q;
    logic [DW-1:0]      data_q;
    logic [WDW-1:0]     wd_q;
    logic               put_req_q, get_req_q, busy_q, ov_q, wd_err_q;
    logic [N_EV-1:0]    rcv_valid_q, freeze_q;
    logic [N_EV*DW-1:0] rcv_data_q;
    logic               adv, wd_hit, rsp_match;

    part_rr_arb #(.N_EV(N_EV)) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (pending_q),
        .adv_i     (adv),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign wd_hit    = (wd_q == WDW'(WD_LIMIT - 1));
    assign rsp_match = fringe.get_valid && (fringe.get_ridx == idx_q);

    // Clears are computed before the set so a same-cycle edge always survives.
    always_comb begin
        ev_edge = clk_h_i & ~clk_h_q & clk_en_i;
        clr     = '0;
        adv     = 1'b0;
        case (state_q)
            S_IDLE: begin
                adv = |pending_q;
                if (!(|(gnt & (put_en_i | get_en_i)))) clr = gnt;
            end
            S_PUT:   if (fringe.put_ack && !get_en_i[idx_q]) clr[idx_q] = 1'b1;
            S_GET:   if (rsp_match) clr[idx_q] = 1'b1;
            default: ;
        endcase
        pending_d = (pending_q & ~clr) | ev_edge;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            clk_h_q     <= '1;
            pending_q   <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            wd_q        <= '0;
            put_req_q   <= 1'b0;
            get_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            ov_q        <= 1'b0;
            wd_err_q    <= 1'b0;
            rcv_valid_q <= '0;
            rcv_data_q  <= '0;
            freeze_q    <= '0;
        end else begin
            clk_h_q     <= clk_h_i;
            pending_q   <= pending_d;
            if (|(ev_edge & pending_q & ~clr)) ov_q <= 1'b1;
            rcv_valid_q <= '0;
            freeze_q    <= pending_q & get_en_i;
            case (state_q)
                S_IDLE: begin
                    if (|pending_q) begin
                        idx_q  <= gnt_idx;
                        data_q <= sut_data_i[gnt_idx*DW +: DW];
                        wd_q   <= '0;
                        if (|(gnt & put_en_i)) begin
                            state_q   <= S_PUT;
                            put_req_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end else if (|(gnt & get_en_i)) begin
                            state_q   <= S_GET;
                            get_req_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                S_PUT: begin
                    if (fringe.put_ack) begin
                        put_req_q <= 1'b0;
                        wd_q      <= '0;
                        if (get_en_i[idx_q]) begin
                            state_q   <= S_GET;
                            get_req_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (wd_hit) begin
                        state_q   <= S_ERR;
                        put_req_q <= 1'b0;
                        wd_err_q  <= 1'b1;
                        freeze_q  <= '1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_GET: begin
                    if (rsp_match) begin
                        rcv_data_q[idx_q*DW +: DW] <= fringe.get_data;
                        rcv_valid_q[idx_q]         <= 1'b1;
                        get_req_q                  <= 1'b0;
                        state_q                    <= S_IDLE;
                        busy_q                     <= 1'b0;
                    end else if (wd_hit) begin
                        state_q   <= S_ERR;
                        get_req_q <= 1'b0;
                        wd_err_q  <= 1'b1;
                        freeze_q  <= '1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: begin
                    // Locked until reset: every mission clock stays held.
                    freeze_q <= '1;
                end
            endcase
        end
    end

    assign fringe.put_req  = put_req_q;
    assign fringe.put_idx  = idx_q;
    assign fringe.put_data = data_q;
    assign fringe.get_req  = get_req_q;
    assign fringe.get_idx  = idx_q;
    assign rcv_valid_o     = rcv_valid_q;
    assign rcv_data_o      = rcv_data_q;
    assign freeze_clk_o    = freeze_q;
    assign busy_o          = busy_q;
    assign ov_err_o        = ov_q;
    assign wd_err_o        = wd_err_q;

endmodule

// File: doc/part_event_sched.md
PART_EVENT_SCHED -- requirements
Module: part_event_sched

Interface
REQ-001 Parameter N_EV, default 4: number of mission-clock event slots.
REQ-002 Parameter DW, default 9: payload width per slot ({wen, data[7:0]}).
REQ-003 Parameter WD_LIMIT, default 10000: watchdog limit in clk_i cycles per transaction.
REQ-004 clk_i  in  1  utility clock; the only clock, all logic posedge clk_i.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 clk_h_i  in  N_EV  mission clock levels, sampled on clk_i.
REQ-007 clk_en_i  in  N_EV  per-slot event enable.
REQ-008 put_en_i / get_en_i  in  N_EV each  per-slot export / import enable.
REQ-009 sut_data_i  in  N_EV*DW  packed export payloads, slot i at bits [i*DW +: DW].
REQ-010 put_req_o  out  1, put_idx_o  out  log2(N_EV), put_data_o  out  DW  export request to fringe channel.
REQ-011 put_ack_i  in  1  fringe accepted put.
REQ-012 get_req_o  out  1, get_idx_o  out  log2(N_EV)  import request.
REQ-013 get_valid_i  in  1, get_ridx_i  in  log2(N_EV), get_data_i  in  DW  import response.
REQ-014 rcv_valid_o  out  N_EV  one-cycle pulse per slot; rcv_data_o  out  N_EV*DW  held received payloads.
REQ-015 freeze_clk_o  out  N_EV  per-slot mission clock hold.
REQ-016 busy_o  out  1  FSM not IDLE; ov_err_o  out  1  sticky overrun; wd_err_o  out  1  sticky watchdog.

Function
REQ-017 Edge detect: edge[i] = clk_h_i[i] & ~clk_h_q[i] & clk_en_i[i]; clk_h_q registers clk_h_i each cycle.
REQ-018 Edge sets pending[i] at next clk_i edge; set wins over same-cycle clear.
REQ-019 Edge on a slot already pending and not being cleared that cycle merges into the pending request and sets ov_err_o.
REQ-020 FSM states IDLE, PUT, GET, ERR.
REQ-021 IDLE: if any pending, a round-robin arbiter grants the lowest pending index strictly after the last grant (wrapping N_EV-1 -> 0; after reset, priority starts at slot 0); idx and sut_data of granted slot latched.
REQ-022 IDLE grant: put_en -> PUT; else get_en -> GET; else pending cleared, remain IDLE.
REQ-023 PUT: put_req_o=1 with stable put_idx_o/put_data_o until the cycle put_ack_i=1; then GET if get_en[idx], else clear pending[idx] and go IDLE.
REQ-024 GET: get_req_o=1 with get_idx_o=idx; on get_valid_i=1 and get_ridx_i==idx: rcv_data slot idx <= get_data_i, rcv_valid_o[idx] pulses one cycle, pending[idx] cleared, go IDLE; responses with a mismatched index are ignored.
REQ-025 Latency: put_req_o rises 2 clk_i cycles after the cycle sampling a rising clk_h_i with FSM idle.
REQ-026 freeze_clk_o[i] = pending[i] & get_en_i[i] from registers; drops the cycle after rcv_valid_o[i].
REQ-027 Watchdog counter cleared on entry to PUT/GET, incremented each cycle there; reaching WD_LIMIT -> ERR.
REQ-028 ERR: wd_err_o=1, put_req_o=get_req_o=0, freeze_clk_o all 1; exit only via rst_i.
REQ-029 Request outputs are registered; no combinational input-to-output path.

Reset
REQ-030 On rst_i: FSM IDLE, pending/rcv_valid_o/rcv_data_o/freeze_clk_o/put_req_o/get_req_o/busy_o/ov_err_o/wd_err_o = 0, watchdog 0.
REQ-031 On rst_i: clk_h_q set to all 1s, so a level-high clk_h_i after reset causes no spurious edge.
REQ-032 rst_i mid-transaction abandons it; outstanding put_ack_i/get_valid_i in the following cycle are ignored.

Structure
REQ-033 Package part_sched_pkg holds the state enum, N_EV/DW/WD_LIMIT defaults and the index-width localparam.
REQ-034 Sub-module part_rr_arb: N_EV-way round-robin arbiter (req vector, advance strobe, one-hot grant plus index).

Verification
REQ-035 Single slot 0, put_en=1, get_en=1, sut=0x1A5: rising clk_h_i[0] -> put_req_o 2 cycles later with data 0x1A5; ack; get_valid idx0 data 0x0C3 -> rcv_data slot0=0x0C3, one-cycle rcv_valid_o[0], freeze_clk_o[0] low next cycle.
REQ-036 Edges on slots 1 and 3 in the same cycle -> served 1 then 3; next simultaneous 1,3 after last grant 3 -> 1 then 3.
REQ-037 get_valid_i with get_ridx_i=2 while serving slot 0 -> ignored, still in GET, no rcv_valid.
REQ-038 WD_LIMIT=16, put_ack_i never asserted -> ERR after 16 cycles in PUT, wd_err_o=1, freeze_clk_o=all 1s, held until rst_i.
REQ-039 Second clk_h_i[2] edge while slot 2 pending -> ov_err_o=1, single transaction issued.
REQ-040 rst_i asserted during GET with clk_h_i held high -> all outputs 0 next cycle, no new request until a fresh rising edge.
